// File: rtl/seq_shift_unit.sv
// Multi-cycle shift unit: one bit position per clock for SLL, SRL, SRA and ROR.
// The result is held in the working register until the consumer accepts it.
module seq_shift_unit #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [1:0]         in_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_zero,
    output logic               busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [1:0] MODE_SLL = 2'b00;
    localparam logic [1:0] MODE_SRA = 2'b10;
    localparam logic [1:0] MODE_ROR = 2'b11;

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   data_reg, data_next;
    logic [SHAMT_W-1:0] count_reg, count_next;
    logic [1:0]         mode_reg, mode_next;

    logic [WIDTH-1:0]   shl_vec;
    logic [WIDTH-1:0]   shr_vec;
    logic [WIDTH-1:0]   shifted;
    logic               fill_bit;

    // Bit shifted into the MSB on right shifts: zero, sign copy or wrapped LSB.
    assign fill_bit = (mode_reg == MODE_SRA) ? data_reg[WIDTH-1] :
                      (mode_reg == MODE_ROR) ? data_reg[0] : 1'b0;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bits
            if (gi == 0) begin : g_lsb
                assign shl_vec[gi] = 1'b0;
            end else begin : g_lsb_n
                assign shl_vec[gi] = data_reg[gi-1];
            end
            if (gi == WIDTH-1) begin : g_msb
                assign shr_vec[gi] = fill_bit;
            end else begin : g_msb_n
                assign shr_vec[gi] = data_reg[gi+1];
            end
        end
    endgenerate

    assign shifted = (mode_reg == MODE_SLL) ? shl_vec : shr_vec;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            data_reg  <= '0;
            count_reg <= '0;
            mode_reg  <= 2'b00;
        end else begin
            state_reg <= state_next;
            data_reg  <= data_next;
            count_reg <= count_next;
            mode_reg  <= mode_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        data_next  = data_reg;
        count_next = count_reg;
        mode_next  = mode_reg;
        case (state_reg)
            ST_IDLE: begin
                if (in_valid) begin
                    data_next  = in_data;
                    count_next = in_shamt;
                    mode_next  = in_mode;
                    state_next = (in_shamt != '0) ? ST_SHIFT : ST_DONE;
                end
            end
            ST_SHIFT: begin
                data_next  = shifted;
                count_next = count_reg - SHAMT_W'(1);
                if (count_reg == SHAMT_W'(1)) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign in_ready  = (state_reg == ST_IDLE);
    assign out_valid = (state_reg == ST_DONE);
    assign busy      = (state_reg != ST_IDLE);
    assign out_data  = data_reg;
    assign out_zero  = (data_reg == '0);

endmodule
